p8_fp32_seq: RTL and testbench
==============================

# p8_fp32_seq

Sequencing controller that feeds packed 8-bit posit words through one shared `p8_fp32` converter instance, one lane per cycle, and emits IEEE-754 single-precision results on a valid/ready stream. It sits between the posit load path, which delivers LANES posits per word, and the FP32 consumer. It adds lane masking, special-value bypass (zero, NaR) and a registered, backpressure-safe output stage around the purely combinational converter.

## Interface
- LANES, 4, posits packed per input word; lane i is in_data[8i+7:8i]; must be ≥2
- IDXW, $clog2(LANES), width of the lane index
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_data  in  8*LANES  packed posit8 lanes
- in_mask  in  LANES  lane enable; bit i=1 → convert lane i
- in_valid  in  1  input word valid
- in_ready  out  1  controller accepts a word
- out_data  out  32  fp32 result
- out_idx  out  IDXW  source lane of out_data
- out_last  out  1  final enabled lane of the word
- out_valid  out  1  output valid
- out_ready  in  1  consumer accepts output
- busy  out  1  a word is held (state RUN)

## Operation
- FSM states: IDLE, RUN.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture in_data→hold_data and in_mask→hold_mask.
  - in_mask==0: word dropped, stay IDLE, no output.
  - Otherwise go RUN with ptr=lowest set bit of in_mask.
- RUN:
  - in_ready=0, busy=1.
  - Converter input = hold_data lane ptr.
  - load = !out_valid || out_ready.
  - On load:
    - out_data←result, out_idx←ptr.
    - out_last←(no set bit of hold_mask above ptr).
    - out_valid←1.
    - Clear hold_mask[ptr].
    - ptr←next set bit above ptr.
    - If out_last: go IDLE.
- Output register:
  - When not loading, out_valid&&out_ready clears out_valid.
  - out_valid&&!out_ready holds out_data/out_idx/out_last stable.
- Result mux:
  - lane==0x00 → 0x00000000.
  - lane==0x80 (NaR) → 0x7FC00000.
  - else → converter output.
- Lanes are emitted in ascending index order. Masked lanes produce nothing and cost no cycles.

## Timing
- Reset values: state IDLE; in_ready=0 while rst high, 1 in the first cycle after release.
- All other outputs reset to 0: out_valid, out_data, out_idx, out_last, busy. hold_data, hold_mask and ptr also reset to 0.
- Latency: word accepted at edge T → first result visible with out_valid=1 after edge T+1.
- With out_ready held high, the n enabled lanes appear on n consecutive cycles (edges T+1..T+n).
- State returns to IDLE at edge T+n, so the next word can be accepted at edge T+n+1.
- Throughput: n results per n+1 cycles.
- Backpressure: out_ready low stalls ptr and hold_mask; no result is lost or duplicated.
- Simultaneous events: the last lane loading at the same edge the previous output drains is legal and gives no bubble. in_valid during RUN is ignored because in_ready=0.
- Reset mid-word: the held word and any pending output are discarded and the FSM goes to IDLE immediately (asynchronous).
- in_data, in_mask and the held word carry no X-dependence after reset; converter input is 0 in IDLE.

## Structure
- Package `p8_pkg`:
  - state enum {IDLE, RUN}.
  - P8_ZERO=8'h00, P8_NAR=8'h80.
  - FP32_ZERO=32'h0000_0000, FP32_NAR=32'h7FC0_0000.
- Sub-module: one instance of the existing combinational `p8_fp32` converter.
- Priority-encoder helpers (lowest set bit, next set bit above ptr) are functions in `p8_pkg`.
- Target size: ~150–250 lines.

## Test plan
- Reset then one word, in_data=0xC0_60_50_40, mask=4'hF, out_ready=1 → outputs on 4 consecutive cycles:
  - idx0 0x3F800000
  - idx1 0x3FC00000
  - idx2 0x40000000
  - idx3 0xBF800000, out_last=1
  - in_ready returns to 1 one cycle later.
- Specials: in_data=0x00_80_80_00, mask=4'hF → 0x00000000, 0x7FC00000, 0x7FC00000, 0x00000000.
- Mask 4'b1010 on word 0x60_00_40_00 → exactly two outputs:
  - idx1 0x3F800000, out_last=0
  - idx3 0x40000000, out_last=1
- Mask 4'h0 → word consumed, in_ready stays 1, no out_valid ever.
- Backpressure: out_ready low for 3 cycles after the first result → out_data/out_idx held stable, busy=1. After release, the remaining lanes arrive in order with no loss or duplicates.
- Assert rst during RUN after the second result → out_valid=0 and busy=0 immediately. After release, a fresh word converts correctly from lane 0.

Source files
------------

// File: rtl/p8_pkg.sv
// Shared types, constants and priority-encoder helpers for the posit8 -> fp32 sequencer.
//   state_e        : controller FSM states
//   P8_* / FP32_*  : special-value encodings bypassed around the converter
//   lowest_set     : index of the lowest set bit of a lane mask
//   next_set_above : index of the lowest set bit strictly above ptr (0 if none)
//   has_set_above  : 1 if any bit strictly above ptr is set
package p8_pkg;

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [7:0]  P8_ZERO   = 8'h00;
  localparam logic [7:0]  P8_NAR    = 8'h80;
  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP32_NAR  = 32'h7FC0_0000;

  // Helpers work on a fixed-width mask; callers zero-extend their LANES-wide masks.
  localparam int unsigned MAX_LANES = 32;
  localparam int unsigned MAX_IDXW  = 5;

  function automatic logic [MAX_IDXW-1:0] lowest_set(input logic [MAX_LANES-1:0] mask);
    logic [MAX_IDXW-1:0] idx;
    idx = '0;
    // Scan downwards so the last hit is the lowest index.
    for (int i = MAX_LANES - 1; i >= 0; i--) begin
      if (mask[i]) idx = MAX_IDXW'(i);
    end
    return idx;
  endfunction

  function automatic logic [MAX_IDXW-1:0] next_set_above(input logic [MAX_LANES-1:0] mask,
                                                         input logic [MAX_IDXW-1:0]  ptr);
    logic [MAX_IDXW-1:0] idx;
    idx = '0;
    for (int i = MAX_LANES - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(ptr))) idx = MAX_IDXW'(i);
    end
    return idx;
  endfunction

  function automatic logic has_set_above(input logic [MAX_LANES-1:0] mask,
                                         input logic [MAX_IDXW-1:0]  ptr);
    logic found;
    found = 1'b0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (mask[i] && (i > int'(ptr))) found = 1'b1;
    end
    return found;
  endfunction

endpackage

// File: rtl/p8_fp32_seq_if.sv
// Stream bundle between the posit load path, the sequencer and the fp32 consumer.
//   in_data/in_mask/in_valid/in_ready : packed posit8 word input (valid/ready)
//   out_data/out_idx/out_last/out_valid/out_ready : fp32 result stream (valid/ready)
//   busy : sequencer is holding a word
// Modport slave is the sequencer side, master is the producer/consumer side.
interface p8_fp32_seq_if #(
  parameter int unsigned LANES = 4,
  parameter int unsigned IDXW  = $clog2(LANES)
);

  logic [8*LANES-1:0] in_data;
  logic [LANES-1:0]   in_mask;
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        out_data;
  logic [IDXW-1:0]    out_idx;
  logic               out_last;
  logic               out_valid;
  logic               out_ready;
  logic               busy;

  modport master (
    output in_data, in_mask, in_valid, out_ready,
    input  in_ready, out_data, out_idx, out_last, out_valid, busy
  );

  modport slave (
    input  in_data, in_mask, in_valid, out_ready,
    output in_ready, out_data, out_idx, out_last, out_valid, busy
  );

endinterface

// File: rtl/p8_fp32.sv
// Combinational posit<8,0> to IEEE-754 single-precision converter.
//   posit : posit8 input word
//   fp32  : converted value (exact; every posit8 value is representable)
// Zero and NaR are not special-cased here; the sequencer bypasses them.
module p8_fp32 (
  input  logic [7:0]  posit,
  output logic [31:0] fp32
);

  logic       sign;
  logic [6:0] body;
  logic [3:0] run;
  logic       found;
  logic [7:0] exp_f;
  logic [6:0] frac;

  always_comb begin
    sign  = posit[7];
    // Low 7 bits of the two's complement magnitude.
    body  = sign ? (~posit[6:0] + 7'd1) : posit[6:0];

    // Regime: run length of bits equal to the leading body bit.
    run   = 4'd0;
    found = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      if (!found) begin
        if (body[i] == body[6]) run = run + 4'd1;
        else                    found = 1'b1;
      end
    end

    // es=0, so scale = k: ones-run gives k=run-1, zeros-run gives k=-run.
    exp_f = body[6] ? (8'd126 + {4'd0, run}) : (8'd127 - {4'd0, run});
    // Dropping regime and terminator leaves the fraction top-aligned.
    frac  = body << (run + 4'd1);
    fp32  = {sign, exp_f, frac, 16'd0};
  end

endmodule

// File: rtl/p8_fp32_seq.sv
// Sequencer feeding packed posit8 lanes through one shared p8_fp32 converter,
// one enabled lane per cycle, onto a registered fp32 valid/ready stream.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : p8_fp32_seq_if slave (input word stream, output result stream, busy)
// Lanes are emitted in ascending index order; masked lanes take no cycles.
// Zero and NaR lanes bypass the converter.
module p8_fp32_seq
  import p8_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned IDXW  = $clog2(LANES)
) (
  input  logic         clk,
  input  logic         rst,
  p8_fp32_seq_if.slave bus
);

  state_e             state_q, state_d;
  logic [8*LANES-1:0] hold_data_q, hold_data_d;
  logic [LANES-1:0]   hold_mask_q, hold_mask_d;
  logic [IDXW-1:0]    ptr_q, ptr_d;
  logic [31:0]        out_data_q, out_data_d;
  logic [IDXW-1:0]    out_idx_q, out_idx_d;
  logic               out_last_q, out_last_d;
  logic               out_valid_q, out_valid_d;

  logic [7:0]         lane;
  logic [31:0]        conv_out;
  logic [31:0]        result;
  logic               load;
  logic               last_lane;
  logic               accept;

  // Converter input is forced to zero outside RUN so nothing toggles while idle.
  assign lane = (state_q == RUN) ? hold_data_q[{ptr_q, 3'b000} +: 8] : P8_ZERO;

  p8_fp32 u_conv (
    .posit (lane),
    .fp32  (conv_out)
  );

  always_comb begin
    if (lane == P8_ZERO)     result = FP32_ZERO;
    else if (lane == P8_NAR) result = FP32_NAR;
    else                     result = conv_out;
  end

  assign bus.in_ready = (state_q == IDLE) && !rst;
  assign accept       = bus.in_valid && bus.in_ready;
  // A new result may enter the output register if it is empty or draining this edge.
  assign load         = (state_q == RUN) && (!out_valid_q || bus.out_ready);
  assign last_lane    = !has_set_above(MAX_LANES'(hold_mask_q), MAX_IDXW'(ptr_q));

  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_mask_d = hold_mask_q;
    ptr_d       = ptr_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q && !bus.out_ready;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          hold_data_d = bus.in_data;
          hold_mask_d = bus.in_mask;
          ptr_d       = IDXW'(lowest_set(MAX_LANES'(bus.in_mask)));
          // An all-masked word is consumed without producing output.
          if (bus.in_mask != '0) state_d = RUN;
        end
      end
      RUN: begin
        if (load) begin
          out_data_d         = result;
          out_idx_d          = ptr_q;
          out_last_d         = last_lane;
          out_valid_d        = 1'b1;
          hold_mask_d[ptr_q] = 1'b0;
          ptr_d              = IDXW'(next_set_above(MAX_LANES'(hold_mask_q), MAX_IDXW'(ptr_q)));
          if (last_lane) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_data_q <= '0;
      hold_mask_q <= '0;
      ptr_q       <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_mask_q <= hold_mask_d;
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q == RUN);

endmodule

// File: tb/tb_p8_fp32_seq.sv
// Directed bench for p8_fp32_seq with LANES=4.
module tb_p8_fp32_seq;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  // Word 0xC0_60_50_40: lanes 1.0, 1.5, 2.0, -1.0
  localparam logic [31:0] EXP_BASIC [4] = '{32'h3F80_0000, 32'h3FC0_0000,
                                            32'h4000_0000, 32'hBF80_0000};
  // Word 0x00_80_80_00: zero, NaR, NaR, zero
  localparam logic [31:0] EXP_SPEC  [4] = '{32'h0000_0000, 32'h7FC0_0000,
                                            32'h7FC0_0000, 32'h0000_0000};

  p8_fp32_seq_if #(.LANES(4)) bus ();

  p8_fp32_seq #(.LANES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word for exactly one edge.
  task automatic send_word(input logic [31:0] data, input logic [3:0] mask);
    bus.in_data  = data;
    bus.in_mask  = mask;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.in_data   = '0;
    bus.in_mask   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    total++; if (bus.out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
    total++; if (bus.out_idx !== 2'd0) begin bad++; $display("FAIL reset_out_idx: got %0d want 0", bus.out_idx); end
    total++; if (bus.out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last: got %b want 0", bus.out_last); end
    rst = 1'b0;
    tick();
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_basic();
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL basic_ready_before: got %b want 1", bus.in_ready); end
    send_word(32'hC060_5040, 4'hF);
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid[%0d]: got %b want 1", i, bus.out_valid); end
      total++; if (bus.out_idx !== 2'(i)) begin bad++; $display("FAIL basic_idx[%0d]: got %0d want %0d", i, bus.out_idx, i); end
      total++; if (bus.out_data !== EXP_BASIC[i]) begin bad++; $display("FAIL basic_data[%0d]: got %h want %h", i, bus.out_data, EXP_BASIC[i]); end
      total++; if (bus.out_last !== (i == 3)) begin bad++; $display("FAIL basic_last[%0d]: got %b want %b", i, bus.out_last, (i == 3)); end
    end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL basic_ready_after: got %b want 1", bus.in_ready); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after: got %b want 0", bus.busy); end
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL basic_drained: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_specials();
    send_word(32'h0080_8000, 4'hF);
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL spec_valid[%0d]: got %b want 1", i, bus.out_valid); end
      total++; if (bus.out_data !== EXP_SPEC[i]) begin bad++; $display("FAIL spec_data[%0d]: got %h want %h", i, bus.out_data, EXP_SPEC[i]); end
    end
    tick();
  endtask

  task automatic test_mask();
    send_word(32'h6000_4000, 4'b1010);
    tick();
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL mask_valid0: got %b want 1", bus.out_valid); end
    total++; if (bus.out_idx !== 2'd1) begin bad++; $display("FAIL mask_idx0: got %0d want 1", bus.out_idx); end
    total++; if (bus.out_data !== 32'h3F80_0000) begin bad++; $display("FAIL mask_data0: got %h want 3f800000", bus.out_data); end
    total++; if (bus.out_last !== 1'b0) begin bad++; $display("FAIL mask_last0: got %b want 0", bus.out_last); end
    tick();
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL mask_valid1: got %b want 1", bus.out_valid); end
    total++; if (bus.out_idx !== 2'd3) begin bad++; $display("FAIL mask_idx1: got %0d want 3", bus.out_idx); end
    total++; if (bus.out_data !== 32'h4000_0000) begin bad++; $display("FAIL mask_data1: got %h want 40000000", bus.out_data); end
    total++; if (bus.out_last !== 1'b1) begin bad++; $display("FAIL mask_last1: got %b want 1", bus.out_last); end
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mask_extra: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_mask_zero();
    send_word(32'h1234_5678, 4'h0);
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mz_valid[%0d]: got %b want 0", i, bus.out_valid); end
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL mz_ready[%0d]: got %b want 1", i, bus.in_ready); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mz_busy[%0d]: got %b want 0", i, bus.busy); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    send_word(32'hC060_5040, 4'hF);
    tick();
    total++; if (bus.out_idx !== 2'd0) begin bad++; $display("FAIL bp_first_idx: got %0d want 0", bus.out_idx); end
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, bus.out_valid); end
      total++; if (bus.out_idx !== 2'd0) begin bad++; $display("FAIL bp_hold_idx[%0d]: got %0d want 0", i, bus.out_idx); end
      total++; if (bus.out_data !== 32'h3F80_0000) begin bad++; $display("FAIL bp_hold_data[%0d]: got %h want 3f800000", i, bus.out_data); end
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL bp_hold_busy[%0d]: got %b want 1", i, bus.busy); end
    end
    bus.out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_rel_valid[%0d]: got %b want 1", i, bus.out_valid); end
      total++; if (bus.out_idx !== 2'(i)) begin bad++; $display("FAIL bp_rel_idx[%0d]: got %0d want %0d", i, bus.out_idx, i); end
      total++; if (bus.out_data !== EXP_BASIC[i]) begin bad++; $display("FAIL bp_rel_data[%0d]: got %h want %h", i, bus.out_data, EXP_BASIC[i]); end
    end
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_drained: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_reset_mid();
    send_word(32'hC060_5040, 4'hF);
    tick();
    tick();
    total++; if (bus.out_idx !== 2'd1) begin bad++; $display("FAIL rm_second_idx: got %0d want 1", bus.out_idx); end
    #1 rst = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rm_out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rm_busy: got %b want 0", bus.busy); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rm_in_ready: got %b want 0", bus.in_ready); end
    tick();
    rst = 1'b0;
    tick();
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rm_ready_after: got %b want 1", bus.in_ready); end
    send_word(32'hC060_5040, 4'hF);
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (bus.out_idx !== 2'(i)) begin bad++; $display("FAIL rm_idx[%0d]: got %0d want %0d", i, bus.out_idx, i); end
      total++; if (bus.out_data !== EXP_BASIC[i]) begin bad++; $display("FAIL rm_data[%0d]: got %h want %h", i, bus.out_data, EXP_BASIC[i]); end
    end
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_specials();
    test_mask();
    test_mask_zero();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
